// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the core run/halt/step sequencer: FSM states,
// debug command opcodes, halt causes and the EBREAK instruction word.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } ctrl_state_e;

    localparam logic [1:0] OP_RUN   = 2'b00;
    localparam logic [1:0] OP_HALT  = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_CMD    = 2'b01;
    localparam logic [1:0] CAUSE_EBREAK = 2'b10;
    localparam logic [1:0] CAUSE_BP     = 2'b11;

    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

endpackage

// File: rtl/ctrl_counter.sv
// Wrap-around event counter with enable and synchronous clear.
// Clear wins over enable, so the increment of a clearing cycle is dropped.
module ctrl_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: zero on clear, +1 (wrapping) when enabled, else hold.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + ONE;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign cnt_o = count_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/halt/single-step sequencer for the single-cycle RISC-V core.
// core_en gates the PC update and register-file writes; a trapping
// instruction (EBREAK or PC breakpoint) is blocked in the same cycle.
// Optional feature macro: BREAKPOINT_EN builds the PC breakpoint comparator;
// without it bp_addr/bp_en are ignored and only EBREAK traps.
module core_run_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int RESET_RUN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      instr_in,
    input  logic [31:0]      bp_addr,
    input  logic             bp_en,
    output logic             core_en,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic             step_done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam ctrl_state_e RESET_STATE  = (RESET_RUN != 0) ? ST_RUN : ST_HALT;
    localparam logic        RESET_HALTED = (RESET_RUN == 0);

    ctrl_state_e state_q;
    logic        halted_q;
    logic [1:0]  haltCause_q;
    logic        stepDone_q;
    logic        skip_q;

    logic        isEbreak;
    logic        isBp;
    logic        trapEff;
    logic [1:0]  trapCause;
    logic        runLike;
    logic        accept;
    logic        clearCmd;

    assign isEbreak = (instr_in == EBREAK_INSTR);

`ifdef BREAKPOINT_EN
    assign isBp = bp_en && (pc_in == bp_addr);
`else
    logic unusedBpInputs;
    assign isBp           = 1'b0;
    assign unusedBpInputs = ^{bp_en, bp_addr, pc_in};
`endif

    // The first cycle after leaving HALT ignores traps so a resume steps
    // over the EBREAK / breakpoint instruction that stopped the core.
    assign trapEff   = (isEbreak || isBp) && !skip_q;
    assign trapCause = isEbreak ? CAUSE_EBREAK : CAUSE_BP;
    assign runLike   = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign core_en   = runLike && !trapEff;
    assign cmd_ready = (state_q != ST_STEP);
    assign accept    = cmd_valid && cmd_ready;
    assign clearCmd  = accept && (cmd_op == OP_CLEAR);

    // Sequencer FSM with registered halted / halt_cause / step_done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RESET_STATE;
            halted_q    <= RESET_HALTED;
            haltCause_q <= CAUSE_NONE;
            stepDone_q  <= 1'b0;
            skip_q      <= 1'b1;
        end else begin
            stepDone_q <= 1'b0;
            case (state_q)
                ST_HALT: begin
                    if (accept && (cmd_op == OP_RUN)) begin
                        state_q     <= ST_RUN;
                        halted_q    <= 1'b0;
                        haltCause_q <= CAUSE_NONE;
                        skip_q      <= 1'b1;
                    end else if (accept && (cmd_op == OP_STEP)) begin
                        state_q  <= ST_STEP;
                        halted_q <= 1'b0;
                        skip_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    skip_q <= 1'b0;
                    if (trapEff) begin
                        state_q     <= ST_HALT;
                        halted_q    <= 1'b1;
                        haltCause_q <= trapCause;
                    end else if (accept && ((cmd_op == OP_HALT) || (cmd_op == OP_STEP))) begin
                        state_q     <= ST_HALT;
                        halted_q    <= 1'b1;
                        haltCause_q <= CAUSE_CMD;
                    end
                end
                ST_STEP: begin
                    skip_q     <= 1'b0;
                    state_q    <= ST_HALT;
                    halted_q   <= 1'b1;
                    stepDone_q <= 1'b1;
                    if (trapEff) begin
                        haltCause_q <= trapCause;
                    end
                end
                default: begin
                    state_q  <= ST_HALT;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    assign halted     = halted_q;
    assign halt_cause = haltCause_q;
    assign step_done  = stepDone_q;

    ctrl_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (1'b1),
        .clr_i (clearCmd),
        .cnt_o (cycle_cnt)
    );

    ctrl_counter #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (core_en),
        .clr_i (clearCmd),
        .cnt_o (retire_cnt)
    );

endmodule
